scan_chain_checker: RTL and testbench

// On-chip scan-chain integrity checker. It is the driving and checking end of the scan

---
 rtl/scan_chain_checker_pkg.sv | 20 ++
 rtl/scan_chain_checker_if.sv | 25 ++
 rtl/scan_chain_checker_pattern_gen.sv | 20 ++
 rtl/scan_chain_checker.sv | 165 ++++++++++++++++
 tb/tb_scan_chain_checker.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/scan_chain_checker_pkg.sv
// Shared types for the scan-chain flush checker.
// State encoding and flush pattern codes.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        PAT_ZERO = 2'd0,
        PAT_ONE  = 2'd1,
        PAT_ALT  = 2'd2
    } pat_e;

    localparam int NUM_PATTERNS = 3;

endpackage

// File: rtl/scan_chain_checker_if.sv
// Scan port bundle between the checker (master) and the chains (slave).
interface scan_chain_checker_if #(
    parameter int NUM_CHAINS = 2
);

    logic                  se;
    logic                  test_mode;
    logic [NUM_CHAINS-1:0] si;
    logic [NUM_CHAINS-1:0] so;

    modport master (
        output se,
        output test_mode,
        output si,
        input  so
    );

    modport slave (
        input  se,
        input  test_mode,
        input  si,
        output so
    );

endinterface

// File: rtl/scan_chain_checker_pattern_gen.sv
// Flush pattern lookup: (pattern id, shift index) -> scan bit.
// Only index mod 4 matters, so the caller passes the low two bits.
module scan_pattern_gen
    import scan_pkg::*;
(
    input  pat_e       pat_i,
    input  logic [1:0] idx_i,
    output logic       bit_o
);

    always_comb begin
        bit_o = 1'b0;
        unique case (pat_i)
            PAT_ONE: bit_o = 1'b1;
            PAT_ALT: bit_o = (idx_i >= 2'd2);
            default: bit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/scan_chain_checker.sv
// Scan-chain integrity checker: drives three flush patterns into every
// chain and compares each scan-out bit against the bit sent CHAIN_LEN earlier.
module scan_chain_checker
    import scan_pkg::*;
#(
    parameter  int CHAIN_LEN  = 10,
    parameter  int NUM_CHAINS = 2,
    localparam int FFW        = $clog2(6 * CHAIN_LEN),
    localparam int KW         = $clog2(2 * CHAIN_LEN)
) (
    input  logic                  refclk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    scan_chain_checker_if.master  scan,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [NUM_CHAINS-1:0] fail_mask,
    output logic [FFW-1:0]        first_fail
);

    localparam logic [KW-1:0] K_LAST = KW'(2 * CHAIN_LEN - 1);
    localparam logic [KW-1:0] K_CMP  = KW'(CHAIN_LEN);
    localparam logic [1:0]    CL_LO  = 2'(CHAIN_LEN % 4);

    state_e                state_q, state_d;
    pat_e                  pat_q, pat_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  se_q, se_d;
    logic                  si_q, si_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [NUM_CHAINS-1:0] fm_q, fm_d;
    logic [FFW-1:0]        ff_q, ff_d;

    logic                  drv_bit;
    logic                  exp_bit;
    logic [1:0]            exp_idx;
    logic [NUM_CHAINS-1:0] mism;
    logic [FFW-1:0]        g;

    // si is registered, so the generator looks at the next-cycle position
    scan_pattern_gen u_drv (
        .pat_i (pat_d),
        .idx_i (k_d[1:0]),
        .bit_o (drv_bit)
    );

    assign exp_idx = k_q[1:0] - CL_LO;

    scan_pattern_gen u_exp (
        .pat_i (pat_q),
        .idx_i (exp_idx),
        .bit_o (exp_bit)
    );

    assign g = FFW'(pat_q) * FFW'(2 * CHAIN_LEN) + FFW'(k_q);

    always_comb begin
        mism = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            mism[i] = (scan.so[i] !== exp_bit);
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        k_d     = k_q;
        se_d    = se_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        fm_d    = fm_q;
        ff_d    = ff_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SETUP;
                    se_d    = 1'b1;
                    pass_d  = 1'b0;
                    fm_d    = '0;
                    ff_d    = '0;
                end
            end
            SETUP: begin
                pat_d = PAT_ZERO;
                k_d   = '0;
                if (abort) begin
                    state_d = IDLE;
                    se_d    = 1'b0;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    se_d    = 1'b0;
                end else begin
                    if (k_q >= K_CMP) begin
                        fm_d = fm_q | mism;
                        if (fm_q == '0 && mism != '0) begin
                            ff_d = g;
                        end
                    end
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        if (pat_q == PAT_ALT) begin
                            state_d = DONE;
                            se_d    = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (fm_d == '0);
                        end else begin
                            pat_d = pat_e'(pat_q + 2'd1);
                        end
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        si_d = (state_d == SHIFT) ? drv_bit : 1'b0;
    end

    always_ff @(posedge refclk) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= PAT_ZERO;
            k_q     <= '0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fm_q    <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            k_q     <= k_d;
            se_q    <= se_d;
            si_q    <= si_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fm_q    <= fm_d;
            ff_q    <= ff_d;
        end
    end

    assign scan.se        = se_q;
    assign scan.test_mode = se_q;
    assign scan.si        = {NUM_CHAINS{si_q}};
    assign busy           = (state_q == SETUP) || (state_q == SHIFT);
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_mask      = fm_q;
    assign first_fail     = ff_q;

endmodule

// File: tb/tb_scan_chain_checker.sv
// Bench for scan_chain_checker: behavioural scan chains with injectable
// faults, expected run results queued and checked when done pulses.
module tb_scan_chain_checker;

    typedef struct {
        bit         pass;
        logic [1:0] fm;
        logic [5:0] ff;
        bit         ckff;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] fail_mask;
    logic [5:0] first_fail;

    logic       stuck1;
    logic       short0;
    logic       xinj;
    logic [9:0] ch0;
    logic [9:0] ch1;
    logic       so0;
    logic       so1;

    int   checks;
    int   errs;
    int   cyc;
    int   start_cyc;
    int   ndone;
    int   n0;
    exp_t sb[$];

    scan_chain_checker_if #(.NUM_CHAINS(2)) sif ();

    scan_chain_checker #(
        .CHAIN_LEN  (10),
        .NUM_CHAINS (2)
    ) dut (
        .refclk     (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .scan       (sif),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_mask  (fail_mask),
        .first_fail (first_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: chain 0 may be one flop short, chain 1 may be stuck at 0
    always @(posedge clk) begin
        if (sif.se) begin
            ch0 <= {ch0[8:0], sif.si[0]};
            ch1 <= {ch1[8:0], sif.si[1]};
        end
    end

    assign so0    = xinj ? 1'bx : (short0 ? ch0[8] : ch0[9]);
    assign so1    = stuck1 ? 1'b0 : ch1[9];
    assign sif.so = {so1, so0};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit p, input logic [1:0] fm,
                                input logic [5:0] ff, input bit ck);
        exp_t e;
        e.pass = p;
        e.fm   = fm;
        e.ff   = ff;
        e.ckff = ck;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            ndone++;
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                e = sb.pop_front();
                chk("latency", cyc - start_cyc, 62);
                chk("pass", {31'd0, pass}, {31'd0, e.pass});
                chk("fail_mask", {30'd0, fail_mask}, {30'd0, e.fm});
                if (e.ckff) begin
                    chk("first_fail", {26'd0, first_fail}, {26'd0, e.ff});
                end
            end
        end
    end

    task automatic pulse_start(input bit rec);
        @(negedge clk);
        start = 1'b1;
        if (rec) start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int t;
        t = 0;
        while (ndone == base && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (ndone == base) begin
            checks++;
            errs++;
            $display("FAIL done_timeout: got no done expected done");
        end
    endtask

    task automatic run(input bit s1, input bit sh0, input bit xi,
                       input exp_t e);
        stuck1 = s1;
        short0 = sh0;
        xinj   = xi;
        sb.push_back(e);
        n0 = ndone;
        pulse_start(1'b1);
        wait_done(n0);
        @(negedge clk);
        stuck1 = 1'b0;
        short0 = 1'b0;
        xinj   = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [1:0] fm,
                                    input logic [5:0] ff);
        chk({tag, "_se"}, {31'd0, sif.se}, 32'd0);
        chk({tag, "_tm"}, {31'd0, sif.test_mode}, 32'd0);
        chk({tag, "_si"}, {30'd0, sif.si}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_fm"}, {30'd0, fail_mask}, {30'd0, fm});
        chk({tag, "_ff"}, {26'd0, first_fail}, {26'd0, ff});
    endtask

    initial begin
        checks = 0;
        errs   = 0;
        ndone  = 0;
        start_cyc = 0;
        reset  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        stuck1 = 1'b0;
        short0 = 1'b0;
        xinj   = 1'b0;
        ch0    = '0;
        ch1    = '0;

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset", 2'b00, 6'd0);
        reset = 1'b1;
        @(negedge clk);

        run(1'b0, 1'b0, 1'b0, mk(1'b1, 2'b00, 6'd0, 1'b1));
        run(1'b1, 1'b0, 1'b0, mk(1'b0, 2'b10, 6'd30, 1'b1));
        run(1'b0, 1'b1, 1'b0, mk(1'b0, 2'b01, 6'd51, 1'b1));

        // abort sampled 20 cycles after start
        pulse_start(1'b0);
        repeat (19) @(negedge clk);
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle_outputs("abort", 2'b00, 6'd0);
        n0 = ndone;
        repeat (70) @(negedge clk);
        chk("abort_no_done", ndone, n0);
        run(1'b0, 1'b0, 1'b0, mk(1'b1, 2'b00, 6'd0, 1'b1));

        // start pulsed mid-shift must not restart or add a done
        sb.push_back(mk(1'b1, 2'b00, 6'd0, 1'b1));
        n0 = ndone;
        pulse_start(1'b1);
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n0);
        repeat (70) @(negedge clk);
        chk("single_done", ndone, n0 + 1);

        // reset mid-shift after a mismatch has been recorded
        stuck1 = 1'b1;
        pulse_start(1'b0);
        repeat (40) @(negedge clk);
        chk("pre_reset_fm", {30'd0, fail_mask}, 32'd2);
        reset = 1'b0;
        @(negedge clk);
        reset  = 1'b1;
        stuck1 = 1'b0;
        chk_idle_outputs("midreset", 2'b00, 6'd0);
        n0 = ndone;
        repeat (70) @(negedge clk);
        chk("midreset_no_done", ndone, n0);

        run(1'b0, 1'b0, 1'b1, mk(1'b0, 2'b01, 6'd0, 1'b0));
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule
